// File: rtl/cp0_except.sv
// cp0_except -- MEM-stage CP0 register file and exception resolver.
//
// Holds Count/Compare/Status/Cause/EPC/PRId, resolves the raw exception
// flags of the instruction in MEM into the excepttype/EPC pair consumed by
// ctrl, and latches EPC, Cause and Status.EXL when an exception is taken.
//
// Build option: CP0_TIMER_EN -- when defined, Count/Compare and the sticky
// timer interrupt exist; otherwise regs 9/11 read 0 and timer_int_o is 0.
//
// Ports
//   clk                 clock, all state on rising edge
//   rst                 asynchronous active-low reset
//   mem_excepttype_i    raw flags [8] sys [9] inv [10] trap [11] ov [12] eret
//   mem_pc_i            PC of the instruction in MEM (0 = bubble)
//   mem_in_delayslot_i  MEM instruction is in a branch delay slot
//   int_i               external interrupt lines (level)
//   we_i/waddr_i/data_i mtc0 write port
//   raddr_i/data_o      mfc0 read port (combinational, write-forwarded)
//   excepttype_o        resolved exception code to ctrl
//   cp0_epc_o           EPC to ctrl (write-forwarded)
//   timer_int_o         sticky timer interrupt
module cp0_except #(
  parameter logic [31:0] PRID_VALUE   = 32'h004c0102,
  parameter logic [31:0] STATUS_RESET = 32'h10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_excepttype_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [5:0]  int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] data_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] cp0_epc_o,
  output logic        timer_int_o
);

  localparam logic [4:0]  REG_COUNT   = 5'd9;
  localparam logic [4:0]  REG_COMPARE = 5'd11;
  localparam logic [4:0]  REG_STATUS  = 5'd12;
  localparam logic [4:0]  REG_CAUSE   = 5'd13;
  localparam logic [4:0]  REG_EPC     = 5'd14;
  localparam logic [4:0]  REG_PRID    = 5'd15;

  // IM[15:8], EXL[1], IE[0]
  localparam logic [31:0] STATUS_WMASK = 32'h0000ff03;
  // software IP[9:8]
  localparam logic [31:0] CAUSE_WMASK  = 32'h00000300;

  localparam logic [31:0] EXC_NONE = 32'h0;
  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_INV  = 32'ha;
  localparam logic [31:0] EXC_TRAP = 32'hd;
  localparam logic [31:0] EXC_OV   = 32'hc;
  localparam logic [31:0] EXC_ERET = 32'he;

  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;

  logic        w_wr_status;
  logic        w_wr_cause;
  logic        w_wr_epc;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_epc;
  logic        w_int_pending;
  logic [31:0] w_excepttype;
  logic        w_taken;
  logic        w_eret;
  logic [4:0]  w_exccode;
  logic [31:0] w_epc_new;
  logic [31:0] w_status_nxt;
  logic [31:0] w_cause_nxt;
  logic [31:0] w_epc_nxt;
  logic [31:0] w_count_rd;
  logic [31:0] w_compare_rd;
  logic        w_unused_flags;

  assign w_unused_flags = ^{mem_excepttype_i[31:13], mem_excepttype_i[7:0]};

  assign w_wr_status = we_i && (waddr_i == REG_STATUS);
  assign w_wr_cause  = we_i && (waddr_i == REG_CAUSE);
  assign w_wr_epc    = we_i && (waddr_i == REG_EPC);

  // Forwarded views: a same-cycle mtc0 is visible to reads and to the
  // exception decision made in this cycle.
  always_comb begin
    w_status = r_status;
    w_cause  = r_cause;
    w_epc    = r_epc;
    if (w_wr_status) w_status = (r_status & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
    if (w_wr_cause)  w_cause  = (r_cause & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
    if (w_wr_epc)    w_epc    = data_i;
  end

  assign w_int_pending = (|(w_cause[15:8] & w_status[15:8])) && !w_status[1] && w_status[0];

  always_comb begin
    w_excepttype = EXC_NONE;
    if (mem_pc_i != 32'h0) begin
      if (w_int_pending)            w_excepttype = EXC_INT;
      else if (mem_excepttype_i[8])  w_excepttype = EXC_SYS;
      else if (mem_excepttype_i[9])  w_excepttype = EXC_INV;
      else if (mem_excepttype_i[10]) w_excepttype = EXC_TRAP;
      else if (mem_excepttype_i[11]) w_excepttype = EXC_OV;
      else if (mem_excepttype_i[12]) w_excepttype = EXC_ERET;
    end
  end

  assign w_taken   = (w_excepttype != EXC_NONE);
  assign w_eret    = (w_excepttype == EXC_ERET);
  // ExcCode equals the excepttype encoding except for interrupts (0).
  assign w_exccode = (w_excepttype == EXC_INT) ? 5'd0 : w_excepttype[4:0];
  assign w_epc_new = mem_in_delayslot_i ? (mem_pc_i - 32'd4) : mem_pc_i;

  // Exception side effects are applied on top of the written values so
  // they win on EXL/BD/ExcCode/EPC while other written bits survive.
  always_comb begin
    w_status_nxt        = w_status;
    w_cause_nxt         = w_cause;
    w_epc_nxt           = w_epc;
    w_cause_nxt[15:10]  = int_i;
    if (w_taken) begin
      if (w_eret) begin
        w_status_nxt[1] = 1'b0;
      end else begin
        w_status_nxt[1]  = 1'b1;
        w_cause_nxt[6:2] = w_exccode;
        // Nested exception (EXL already set) keeps the original EPC/BD.
        if (!w_status[1]) begin
          w_cause_nxt[31] = mem_in_delayslot_i;
          w_epc_nxt       = w_epc_new;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_status <= STATUS_RESET;
      r_cause  <= 32'h0;
      r_epc    <= 32'h0;
    end else begin
      r_status <= w_status_nxt;
      r_cause  <= w_cause_nxt;
      r_epc    <= w_epc_nxt;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timer_int;
  logic        w_wr_count;
  logic        w_wr_compare;

  assign w_wr_count   = we_i && (waddr_i == REG_COUNT);
  assign w_wr_compare = we_i && (waddr_i == REG_COMPARE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count     <= 32'h0;
      r_compare   <= 32'h0;
      r_timer_int <= 1'b0;
    end else begin
      r_count <= w_wr_count ? data_i : (r_count + 32'd1);
      if (w_wr_compare) begin
        r_compare   <= data_i;
        r_timer_int <= 1'b0;
      end else if ((r_compare != 32'h0) && (r_count == r_compare)) begin
        r_timer_int <= 1'b1;
      end
    end
  end

  assign w_count_rd   = w_wr_count   ? data_i : r_count;
  assign w_compare_rd = w_wr_compare ? data_i : r_compare;
  assign timer_int_o  = r_timer_int;
`else
  assign w_count_rd   = 32'h0;
  assign w_compare_rd = 32'h0;
  assign timer_int_o  = 1'b0;
`endif

  always_comb begin
    case (raddr_i)
      REG_COUNT:   data_o = w_count_rd;
      REG_COMPARE: data_o = w_compare_rd;
      REG_STATUS:  data_o = w_status;
      REG_CAUSE:   data_o = w_cause;
      REG_EPC:     data_o = w_epc;
      REG_PRID:    data_o = PRID_VALUE;
      default:     data_o = 32'h0;
    endcase
  end

  assign excepttype_o = w_excepttype;
  assign cp0_epc_o    = w_epc;

endmodule

// File: tb/tb_cp0_except.sv
module tb_cp0_except;

  localparam logic [31:0] PRID = 32'h004c0102;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_excepttype;
  logic [31:0] mem_pc;
  logic        ds;
  logic [5:0]  int_in;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] data_o;
  logic [31:0] excepttype_o;
  logic [31:0] cp0_epc_o;
  logic        timer_int_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  cp0_except dut (
    .clk                (clk),
    .rst                (rst),
    .mem_excepttype_i   (mem_excepttype),
    .mem_pc_i           (mem_pc),
    .mem_in_delayslot_i (ds),
    .int_i              (int_in),
    .we_i               (we),
    .waddr_i            (waddr),
    .data_i             (wdata),
    .raddr_i            (raddr),
    .data_o             (data_o),
    .excepttype_o       (excepttype_o),
    .cp0_epc_o          (cp0_epc_o),
    .timer_int_o        (timer_int_o)
  );

  // Architectural state of the reference model.
  logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
  logic        m_tint;
  logic [31:0] n_status, n_cause, n_epc, n_count, n_compare;
  logic        n_tint;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_status = 32'h10000000; m_cause = 0; m_epc = 0;
    m_count = 0; m_compare = 0; m_tint = 1'b0;
  endtask

  // Register views as software sees them this cycle, including a pending mtc0.
  task automatic views(output logic [31:0] s, output logic [31:0] c, output logic [31:0] e);
    s = m_status; c = m_cause; e = m_epc;
    if (we && waddr == 5'd12) s = {m_status[31:16], wdata[15:8], m_status[7:2], wdata[1:0]};
    if (we && waddr == 5'd13) c = {m_cause[31:10], wdata[9:8], m_cause[7:0]};
    if (we && waddr == 5'd14) e = wdata;
  endtask

  function automatic logic [31:0] resolve(input logic [31:0] s, input logic [31:0] c);
    logic [31:0] codes [5];
    codes[0] = 32'h8; codes[1] = 32'ha; codes[2] = 32'hd; codes[3] = 32'hc; codes[4] = 32'he;
    if (mem_pc == 0) return 32'h0;
    if ((((c >> 8) & (s >> 8) & 32'hff) != 0) && s[1] == 1'b0 && s[0] == 1'b1) return 32'h1;
    for (int k = 0; k < 5; k++)
      if (mem_excepttype[8 + k]) return codes[k];
    return 32'h0;
  endfunction

  task automatic compare_all();
    logic [31:0] s, c, e, rd;
    views(s, c, e);
    case (raddr)
      5'd9:    rd = m_count;
      5'd11:   rd = m_compare;
      5'd12:   rd = s;
      5'd13:   rd = c;
      5'd14:   rd = e;
      5'd15:   rd = PRID;
      default: rd = 0;
    endcase
`ifndef CP0_TIMER_EN
    if (raddr == 5'd9 || raddr == 5'd11) rd = 0;
`endif
    chk("data_o", data_o, rd);
    chk("excepttype_o", excepttype_o, resolve(s, c));
    chk("cp0_epc_o", cp0_epc_o, e);
    chk("timer_int_o", {31'b0, timer_int_o}, {31'b0, m_tint});
  endtask

  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic model_next();
    logic [31:0] s, c, e, t;
    views(s, c, e);
    t = resolve(s, c);
    n_status = s; n_cause = c; n_epc = e;
    n_cause[15:10] = int_in;
    if (t == 32'he) n_status[1] = 1'b0;
    else if (t != 0) begin
      n_status[1] = 1'b1;
      n_cause[6:2] = (t == 32'h1) ? 5'd0 : t[4:0];
      if (!s[1]) begin
        n_cause[31] = ds;
        n_epc = ds ? mem_pc - 4 : mem_pc;
      end
    end
    n_count = m_count; n_compare = m_compare; n_tint = m_tint;
`ifdef CP0_TIMER_EN
    n_count = (we && waddr == 5'd9) ? wdata : m_count + 1;
    if (we && waddr == 5'd11) begin
      n_compare = wdata; n_tint = 1'b0;
    end else if (m_compare != 0 && m_count == m_compare) n_tint = 1'b1;
`endif
  endtask

  task automatic tick();
    model_next();
    @(posedge clk);
    m_status = n_status; m_cause = n_cause; m_epc = n_epc;
    m_count = n_count; m_compare = n_compare; m_tint = n_tint;
    @(negedge clk);
  endtask

  task automatic idle();
    mem_excepttype = 0; mem_pc = 0; ds = 0; int_in = 0;
    we = 0; waddr = 0; wdata = 0; raddr = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    idle(); we = 1; waddr = a; wdata = d;
    settle(); tick();
  endtask

  logic [4:0] addr_pick [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, n_total %0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    addr_pick[0] = 5'd9;  addr_pick[1] = 5'd11; addr_pick[2] = 5'd12; addr_pick[3] = 5'd13;
    addr_pick[4] = 5'd14; addr_pick[5] = 5'd15; addr_pick[6] = 5'd0;
    idle();
    rst = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    // Reset values
    raddr = 12; settle(); chk("rst_status", data_o, 32'h10000000);
    chk("rst_type", excepttype_o, 32'h0);
    raddr = 13; settle(); chk("rst_cause", data_o, 32'h0);
    raddr = 14; settle(); chk("rst_epc", data_o, 32'h0);
    raddr = 15; settle(); chk("rst_prid", data_o, PRID);
    tick();

    // Syscall, not in a delay slot
    idle(); mem_pc = 32'h00400100; mem_excepttype = 32'h100;
    settle(); chk("sys_type", excepttype_o, 32'h8);
    tick();
    idle();
    raddr = 14; settle(); chk("sys_epc", data_o, 32'h00400100);
    raddr = 12; settle(); chk("sys_status", data_o, 32'h10000002);
    raddr = 13; settle(); chk("sys_cause", data_o, 32'h00000020);
    tick();

    // Overflow in a delay slot (EXL cleared first)
    wr(5'd12, 32'h0);
    idle(); mem_pc = 32'h00400208; ds = 1; mem_excepttype = 32'h800;
    settle(); chk("ov_type", excepttype_o, 32'hc);
    tick();
    idle();
    raddr = 14; settle(); chk("ov_epc", data_o, 32'h00400204);
    raddr = 13; settle(); chk("ov_cause", data_o, 32'h80000030);
    tick();

    // Interrupt beats syscall
    wr(5'd12, 32'h00000401);
    idle(); int_in = 6'b000001; settle(); tick();
    idle(); mem_pc = 32'h00400300; mem_excepttype = 32'h100;
    settle(); chk("int_type", excepttype_o, 32'h1);
    tick();
    idle();
    raddr = 13; settle(); chk("int_cause", data_o, 32'h0);
    raddr = 12; settle(); chk("int_status", data_o, 32'h10000403);
    raddr = 14; settle(); chk("int_epc", data_o, 32'h00400300);
    tick();

    // eret, then eret with a same-cycle EPC write
    idle(); mem_pc = 32'h00400310; mem_excepttype = 32'h1000;
    settle(); chk("eret_type", excepttype_o, 32'he);
    chk("eret_epc", cp0_epc_o, 32'h00400300);
    tick();
    idle(); raddr = 12; settle(); chk("eret_status", data_o, 32'h10000401);
    tick();
    idle(); mem_pc = 32'h00400314; mem_excepttype = 32'h1000;
    we = 1; waddr = 14; wdata = 32'h00400400;
    settle(); chk("eret_fwd_type", excepttype_o, 32'he);
    chk("eret_fwd_epc", cp0_epc_o, 32'h00400400);
    tick();
    idle(); raddr = 14; settle(); chk("eret_fwd_hold", data_o, 32'h00400400);
    tick();

    // Timer
    wr(5'd11, 32'd5);
    wr(5'd9, 32'd0);
    idle();
    for (int k = 0; k < 4; k++) begin settle(); tick(); end
    settle(); chk("tmr_early", {31'b0, timer_int_o}, 32'h0);
    for (int k = 0; k < 2; k++) begin settle(); tick(); end
    raddr = 9; settle();
`ifdef CP0_TIMER_EN
    chk("tmr_set", {31'b0, timer_int_o}, 32'h1);
    chk("tmr_count", data_o, 32'd6);
`else
    chk("tmr_set", {31'b0, timer_int_o}, 32'h0);
    chk("tmr_count", data_o, 32'd0);
`endif
    tick();
    wr(5'd11, 32'h0);
    idle(); settle(); chk("tmr_clear", {31'b0, timer_int_o}, 32'h0);
    tick();

    // Randomized traffic, with an asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        idle(); raddr = 12; mem_pc = 32'h00400000; mem_excepttype = 32'h100;
        #1;
        rst = 1'b0;
        model_reset();
        settle();
        chk("mid_rst_status", data_o, 32'h10000000);
        chk("mid_rst_type", excepttype_o, 32'h8);
        chk("mid_rst_epc", cp0_epc_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
      end
      mem_pc = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom & 32'h00fffffc);
      ds = 1'($urandom_range(0, 1));
      mem_excepttype = $urandom & ~32'h00001f00;
      for (int b = 8; b < 13; b++)
        if ($urandom_range(0, 5) == 0) mem_excepttype[b] = 1'b1;
      int_in = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      we = ($urandom_range(0, 3) == 0);
      waddr = addr_pick[$urandom_range(0, 6)];
      if (waddr == 0) waddr = 5'($urandom);
      wdata = $urandom;
      if (waddr == 5'd11 && $urandom_range(0, 2) == 0) wdata = m_count + $urandom_range(1, 8);
      raddr = addr_pick[$urandom_range(0, 6)];
      if (raddr == 0) raddr = 5'($urandom);
      if (we && (waddr == 5'd9 || waddr == 5'd11) && raddr == waddr) raddr = 5'd12;
      settle();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
